seg_scan_controller: RTL and testbench

Time-multiplexing scan controller for the stopwatch display. It drives one shared seven-segment decoder across NUM_DIGITS common-anode digits. Each frame it snapshots the BCD time value, steps a digit index on a fixed dwell period, and inserts a guard (all-off) interval before each digit to prevent ghosting. It also handles leading-zero blanking and invalid-code suppression. It sits between the stopwatch counter and the decoder/anode pins.

---
 rtl/seg_scan_controller.sv | 120 ++++++++++++
 tb/tb_seg_scan_controller.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_controller.sv
// Time-multiplexed seven-segment scan controller: snapshots a BCD value once per frame and
// steps one shared decoder across the digits, with a guard gap, blanking and bad-code suppression.
module seg_scan_controller #(
    parameter int unsigned NumDigits = 4,
    parameter int unsigned Dwell     = 50000,
    parameter int unsigned Guard     = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [4*NumDigits-1:0] digits_i,
    input  logic [NumDigits-1:0]   dp_mask_i,
    input  logic                   blank_lz_i,
    output logic [3:0]             bcd_o,
    output logic [NumDigits-1:0]   anode_n_o,
    output logic                   dp_o,
    output logic                   frame_start_o,
    output logic                   invalid_seen_o
);

    localparam int unsigned CntW = (Dwell > 1) ? $clog2(Dwell) : 1;
    localparam int unsigned IdxW = (NumDigits > 1) ? $clog2(NumDigits) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(Dwell - 1);
    localparam logic [CntW-1:0] GuardLen = CntW'(Guard);
    localparam logic [IdxW-1:0] IdxMax = IdxW'(NumDigits - 1);

    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [IdxW-1:0]        idx_q, idx_d;
    logic [4*NumDigits-1:0] snap_q, snap_d;
    logic                   invalid_seen_q, invalid_seen_d;

    logic [3:0]           bcd_q, bcd_d;
    logic [NumDigits-1:0] anode_n_q, anode_n_d;
    logic                 dp_q, dp_d;
    logic                 frame_start_q, frame_start_d;

    logic slot_end, frame_end, digits_bad;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q          <= '0;
            idx_q          <= '0;
            snap_q         <= '0;
            invalid_seen_q <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            snap_q         <= snap_d;
            invalid_seen_q <= invalid_seen_d;
        end
    end

    // Next-state logic
    always_comb begin
        slot_end  = (cnt_q == CntMax);
        frame_end = slot_end && (idx_q == IdxMax);

        digits_bad = 1'b0;
        for (int i = 0; i < int'(NumDigits); i++) begin
            if (digits_i[4*i +: 4] > 4'd9) digits_bad = 1'b1;
        end

        cnt_d = slot_end ? '0 : cnt_q + CntW'(1);
        idx_d = idx_q;
        if (slot_end) idx_d = (idx_q == IdxMax) ? '0 : idx_q + IdxW'(1);

        snap_d         = frame_end ? digits_i : snap_q;
        invalid_seen_d = invalid_seen_q | (frame_end & digits_bad);
    end

    // Output logic: computed from next state so the registered outputs line up with cnt_q/idx_q
    logic [3:0]           nib;
    logic [NumDigits-1:0] upper_zero;
    logic                 acc_zero, nib_bad, blanked, show, lit;

    always_comb begin
        nib = snap_d[4*idx_d +: 4];

        // upper_zero[i]: snapped digits i..NumDigits-1 are all zero
        acc_zero   = 1'b1;
        upper_zero = '0;
        for (int i = int'(NumDigits) - 1; i >= 0; i--) begin
            acc_zero      = acc_zero & (snap_d[4*i +: 4] == 4'd0);
            upper_zero[i] = acc_zero;
        end

        nib_bad = (nib > 4'd9);
        blanked = blank_lz_i && (idx_d != '0) && upper_zero[idx_d];
        show    = (cnt_d >= GuardLen);
        lit     = show && !blanked && !nib_bad;

        bcd_d     = nib_bad ? 4'd0 : nib;
        anode_n_d = '1;
        if (lit) anode_n_d[idx_d] = 1'b0;
        dp_d          = lit & dp_mask_i[idx_d];
        frame_start_d = frame_end;
    end

    // Output register; reset clears anodes immediately, mid-slot included
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bcd_q         <= 4'd0;
            anode_n_q     <= '1;
            dp_q          <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            bcd_q         <= bcd_d;
            anode_n_q     <= anode_n_d;
            dp_q          <= dp_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bcd_o          = bcd_q;
    assign anode_n_o      = anode_n_q;
    assign dp_o           = dp_q;
    assign frame_start_o  = frame_start_q;
    assign invalid_seen_o = invalid_seen_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Directed bench for seg_scan_controller with Dwell=8, Guard=2, four digits (frame = 32 cycles).
module tb_seg_scan_controller;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [15:0] digits_i = 16'h0;
    logic [3:0]  dp_mask_i = 4'h0;
    logic        blank_lz_i = 1'b0;
    logic [3:0]  bcd_o;
    logic [3:0]  anode_n_o;
    logic        dp_o;
    logic        frame_start_o;
    logic        invalid_seen_o;

    int n_checks = 0;
    int n_fail = 0;
    int cur = 0;

    seg_scan_controller #(
        .NumDigits(4),
        .Dwell    (8),
        .Guard    (2)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .digits_i      (digits_i),
        .dp_mask_i     (dp_mask_i),
        .blank_lz_i    (blank_lz_i),
        .bcd_o         (bcd_o),
        .anode_n_o     (anode_n_o),
        .dp_o          (dp_o),
        .frame_start_o (frame_start_o),
        .invalid_seen_o(invalid_seen_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          rst;
        int          cyc;
        logic [15:0] digits;
        logic [3:0]  dpm;
        logic        blz;
        logic [3:0]  bcd;
        logic [3:0]  an;
        logic        dp;
        logic        fs;
        logic        inv;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit r, int c, logic [15:0] d, logic [3:0] m, logic b,
                                logic [3:0] eb, logic [3:0] ea, logic edp, logic efs,
                                logic einv);
        vec_t v;
        v.rst = r; v.cyc = c; v.digits = d; v.dpm = m; v.blz = b;
        v.bcd = eb; v.an = ea; v.dp = edp; v.fs = efs; v.inv = einv;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cur, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
        cur++;
    endtask

    task automatic goto(input int c);
        while (cur < c) step();
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        cur = 0;
    endtask

    logic [3:0] prev_bcd;

    initial begin
        // Scenario 1: reset and first frames
        vecs.push_back(mk(1,  0, 16'h1234, 4'b0001, 0, 0, 4'hF, 0, 0, 0));
        vecs.push_back(mk(0,  1, 16'h1234, 4'b0001, 0, 0, 4'hF, 0, 0, 0));
        vecs.push_back(mk(0,  2, 16'h1234, 4'b0001, 0, 0, 4'hE, 1, 0, 0));
        vecs.push_back(mk(0,  7, 16'h1234, 4'b0001, 0, 0, 4'hE, 1, 0, 0));
        vecs.push_back(mk(0,  8, 16'h1234, 4'b0001, 0, 0, 4'hF, 0, 0, 0));
        vecs.push_back(mk(0, 10, 16'h1234, 4'b0001, 0, 0, 4'hD, 0, 0, 0));
        vecs.push_back(mk(0, 26, 16'h1234, 4'b0001, 0, 0, 4'h7, 0, 0, 0));
        vecs.push_back(mk(0, 31, 16'h1234, 4'b0001, 0, 0, 4'h7, 0, 0, 0));
        vecs.push_back(mk(0, 32, 16'h1234, 4'b0001, 0, 4, 4'hF, 0, 1, 0));
        vecs.push_back(mk(0, 33, 16'h1234, 4'b0001, 0, 4, 4'hF, 0, 0, 0));
        vecs.push_back(mk(0, 34, 16'h1234, 4'b0001, 0, 4, 4'hE, 1, 0, 0));
        vecs.push_back(mk(0, 42, 16'h1234, 4'b0001, 0, 3, 4'hD, 0, 0, 0));
        vecs.push_back(mk(0, 50, 16'h1234, 4'b0001, 0, 2, 4'hB, 0, 0, 0));
        vecs.push_back(mk(0, 56, 16'h1234, 4'b0001, 0, 1, 4'hF, 0, 0, 0));
        vecs.push_back(mk(0, 58, 16'h1234, 4'b0001, 0, 1, 4'h7, 0, 0, 0));
        vecs.push_back(mk(0, 64, 16'h1234, 4'b0001, 0, 4, 4'hF, 0, 1, 0));
        // Scenario 3: leading-zero blanking (frame 1 holds the all-zero snapshot)
        vecs.push_back(mk(1,  2, 16'h0050, 4'b1111, 1, 0, 4'hE, 1, 0, 0));
        vecs.push_back(mk(0, 10, 16'h0050, 4'b1111, 1, 0, 4'hF, 0, 0, 0));
        vecs.push_back(mk(0, 18, 16'h0050, 4'b1111, 1, 0, 4'hF, 0, 0, 0));
        vecs.push_back(mk(0, 26, 16'h0050, 4'b1111, 1, 0, 4'hF, 0, 0, 0));
        vecs.push_back(mk(0, 34, 16'h0050, 4'b1111, 1, 0, 4'hE, 1, 0, 0));
        vecs.push_back(mk(0, 42, 16'h0050, 4'b1111, 1, 5, 4'hD, 1, 0, 0));
        vecs.push_back(mk(0, 50, 16'h0050, 4'b1111, 1, 0, 4'hF, 0, 0, 0));
        vecs.push_back(mk(0, 58, 16'h0050, 4'b1111, 1, 0, 4'hF, 0, 0, 0));
        // Scenario 4: invalid nibble in digit 1, then a valid value; flag stays sticky
        vecs.push_back(mk(1,  0, 16'h12A4, 4'b0000, 0, 0, 4'hF, 0, 0, 0));
        vecs.push_back(mk(0, 31, 16'h12A4, 4'b0000, 0, 0, 4'h7, 0, 0, 0));
        vecs.push_back(mk(0, 32, 16'h12A4, 4'b0000, 0, 4, 4'hF, 0, 1, 1));
        vecs.push_back(mk(0, 34, 16'h12A4, 4'b0000, 0, 4, 4'hE, 0, 0, 1));
        vecs.push_back(mk(0, 42, 16'h12A4, 4'b0000, 0, 0, 4'hF, 0, 0, 1));
        vecs.push_back(mk(0, 47, 16'h12A4, 4'b0000, 0, 0, 4'hF, 0, 0, 1));
        vecs.push_back(mk(0, 50, 16'h12A4, 4'b0000, 0, 2, 4'hB, 0, 0, 1));
        vecs.push_back(mk(0, 58, 16'h12A4, 4'b0000, 0, 1, 4'h7, 0, 0, 1));
        vecs.push_back(mk(0, 66, 16'h1234, 4'b0000, 0, 4, 4'hE, 0, 0, 1));
        vecs.push_back(mk(0, 74, 16'h1234, 4'b0000, 0, 3, 4'hD, 0, 0, 1));
        // Scenario 5: digits change mid-frame; dp only in SHOW of slot 2
        vecs.push_back(mk(1, 34, 16'h0999, 4'b0100, 0, 9, 4'hE, 0, 0, 0));
        vecs.push_back(mk(0, 42, 16'h1000, 4'b0100, 0, 9, 4'hD, 0, 0, 0));
        vecs.push_back(mk(0, 48, 16'h1000, 4'b0100, 0, 9, 4'hF, 0, 0, 0));
        vecs.push_back(mk(0, 50, 16'h1000, 4'b0100, 0, 9, 4'hB, 1, 0, 0));
        vecs.push_back(mk(0, 55, 16'h1000, 4'b0100, 0, 9, 4'hB, 1, 0, 0));
        vecs.push_back(mk(0, 58, 16'h1000, 4'b0100, 0, 0, 4'h7, 0, 0, 0));
        vecs.push_back(mk(0, 64, 16'h1000, 4'b0100, 0, 0, 4'hF, 0, 1, 0));
        vecs.push_back(mk(0, 66, 16'h1000, 4'b0100, 0, 0, 4'hE, 0, 0, 0));
        vecs.push_back(mk(0, 82, 16'h1000, 4'b0100, 0, 0, 4'hB, 1, 0, 0));
        vecs.push_back(mk(0, 90, 16'h1000, 4'b0100, 0, 1, 4'h7, 0, 0, 0));

        foreach (vecs[i]) begin
            digits_i   = vecs[i].digits;
            dp_mask_i  = vecs[i].dpm;
            blank_lz_i = vecs[i].blz;
            if (vecs[i].rst) do_reset();
            goto(vecs[i].cyc);
            chk("bcd", 32'(bcd_o), 32'(vecs[i].bcd));
            chk("anode_n", 32'(anode_n_o), 32'(vecs[i].an));
            chk("dp", 32'(dp_o), 32'(vecs[i].dp));
            chk("frame_start", 32'(frame_start_o), 32'(vecs[i].fs));
            chk("invalid_seen", 32'(invalid_seen_o), 32'(vecs[i].inv));
        end

        // Scenario 2: ten frames of per-cycle guard, exclusivity and stability checks
        digits_i   = 16'h1234;
        dp_mask_i  = 4'b0001;
        blank_lz_i = 1'b0;
        do_reset();
        prev_bcd = bcd_o;
        for (int c = 0; c < 320; c++) begin
            chk("anode_exclusive", 32'($countones(~anode_n_o) <= 1), 32'd1);
            if (c % 8 < 2) chk("guard_off", 32'(anode_n_o), 32'hF);
            else chk("show_on", 32'($countones(~anode_n_o)), 32'd1);
            if (c % 8 != 0) chk("bcd_stable", 32'(bcd_o), 32'(prev_bcd));
            chk("fs_spacing", 32'(frame_start_o), 32'((c > 0) && (c % 32 == 0)));
            prev_bcd = bcd_o;
            step();
        end

        // Scenario 6: asynchronous reset at slot 2, cnt 5 of frame 2
        do_reset();
        goto(53);
        chk("pre_reset_anode", 32'(anode_n_o), 32'hB);
        chk("pre_reset_bcd", 32'(bcd_o), 32'd2);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("async_anode", 32'(anode_n_o), 32'hF);
        chk("async_bcd", 32'(bcd_o), 32'd0);
        chk("async_idx", 32'(dut.idx_q), 32'd0);
        chk("async_fs", 32'(frame_start_o), 32'd0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        cur = 0;
        goto(2);
        chk("restart_anode", 32'(anode_n_o), 32'hE);
        chk("restart_bcd", 32'(bcd_o), 32'd0);
        goto(31);
        chk("restart_no_fs", 32'(frame_start_o), 32'd0);
        goto(32);
        chk("restart_fs", 32'(frame_start_o), 32'd1);
        chk("restart_bcd_f2", 32'(bcd_o), 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cur);
        $fatal(1);
    end

endmodule
